// File: rtl/loader_pkg.sv
// Types and helpers shared by the boot-time code loader.
//   state_t  : loader FSM states
//   LEN_MAX  : largest accepted frame length for the default code memory
//   len_max  : largest accepted frame length for a given address width
//   len_ok   : frame length acceptance test (1..2^width words)
`include "constants.svh"

package loader_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LEN_LO,
    DATA_HI,
    DATA_LO,
    SUM_HI,
    SUM_LO,
    RUN
  } state_t;

  localparam int unsigned LEN_MAX = 1 << `CODE_ADDR_WIDTH;

  function automatic int unsigned len_max(input int unsigned width);
    return 32'd1 << width;
  endfunction

  // A frame must carry at least one word and must fit the code memory,
  // which is what lets the write address run without ever wrapping.
  function automatic logic len_ok(input logic [15:0] n, input int unsigned width);
    return (n != 16'd0) && (32'(n) <= len_max(width));
  endfunction

endpackage

// File: rtl/constants.svh
// Shared build-time constants for the code memory subsystem.
//   CODE_ADDR_WIDTH : address width of the CPU code memory (words).
`ifndef CONSTANTS_SVH
`define CONSTANTS_SVH

`define CODE_ADDR_WIDTH 13

`endif

// File: rtl/idle_timer.sv
// Inter-byte idle timer for the code loader.
//   clk     : system clock
//   reset   : synchronous, active-high
//   clear   : a byte was accepted this cycle; restart the count
//   enable  : loader is inside a frame; when low the count holds at 0
//   expired : TIMEOUT_CYCLES idle cycles have elapsed without a byte
module idle_timer #(
  parameter int unsigned TIMEOUT_CYCLES = 1_000_000
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int unsigned CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYCLES - 1);

  logic [CW-1:0] count;

  always_ff @(posedge clk) begin
    if (reset || !enable || clear) begin
      count <= '0;
    end else if (count != LAST) begin
      count <= count + CW'(1);
    end
  end

  // A byte in the terminal cycle wins: clear masks the expiry.
  assign expired = enable && !clear && (count == LAST);

endmodule

// File: rtl/code_loader.sv
// Boot-time program loader. Receives a framed byte stream
// (LEN hi/lo, N data words hi/lo, SUM hi/lo), writes the words to code
// memory from address 0, holds the CPU in reset while loading and, after a
// checksum match, releases it with a single resume pulse.
//   clk        : system clock
//   reset      : synchronous, active-high
//   rx_valid   : single-cycle byte strobe (no backpressure)
//   rx_data    : received byte
//   code_we    : code memory write enable (one cycle per word)
//   code_waddr : code memory write address
//   code_wdata : code memory write data
//   cpu_reset  : CPU reset, low only while running a verified image
//   cpu_resume : one-cycle resume pulse at release
//   load_error : sticky, the last frame was rejected
`include "constants.svh"

module code_loader
  import loader_pkg::*;
#(
  parameter int unsigned CODE_WIDTH     = `CODE_ADDR_WIDTH,
  parameter int unsigned TIMEOUT_CYCLES = 1_000_000
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  rx_valid,
  input  logic [7:0]            rx_data,
  output logic                  code_we,
  output logic [CODE_WIDTH-1:0] code_waddr,
  output logic [15:0]           code_wdata,
  output logic                  cpu_reset,
  output logic                  cpu_resume,
  output logic                  load_error
);

  state_t              state;
  logic [7:0]          len_hi;
  logic [15:0]         len;
  logic [7:0]          word_hi;
  logic [7:0]          sum_hi;
  logic [15:0]         sum;
  logic [CODE_WIDTH:0] wcnt;

  logic                in_frame;
  logic                expired;
  logic [15:0]         len_in;
  logic [15:0]         word_in;
  logic [15:0]         sum_in;
  logic                last_word;

  assign in_frame  = (state == LEN_LO) || (state == DATA_HI) || (state == DATA_LO) ||
                     (state == SUM_HI) || (state == SUM_LO);
  assign len_in    = {len_hi, rx_data};
  assign word_in   = {word_hi, rx_data};
  assign sum_in    = {sum_hi, rx_data};
  // wcnt counts words already written; the current word is the last one
  // when it brings the count up to LEN.
  assign last_word = ((32'(wcnt) + 32'd1) == 32'(len));

  idle_timer #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_idle_timer (
    .clk    (clk),
    .reset  (reset),
    .clear  (rx_valid),
    .enable (in_frame),
    .expired(expired)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      len_hi     <= '0;
      len        <= '0;
      word_hi    <= '0;
      sum_hi     <= '0;
      sum        <= '0;
      wcnt       <= '0;
      code_we    <= 1'b0;
      code_waddr <= '0;
      code_wdata <= '0;
      cpu_reset  <= 1'b1;
      cpu_resume <= 1'b0;
      load_error <= 1'b0;
    end else begin
      code_we    <= 1'b0;
      cpu_resume <= 1'b0;
      if (expired) begin
        state      <= IDLE;
        load_error <= 1'b1;
        cpu_reset  <= 1'b1;
      end else if (rx_valid) begin
        case (state)
          // First byte of a frame; from RUN this is a reload and puts the
          // CPU back into reset straight away.
          IDLE, RUN: begin
            len_hi     <= rx_data;
            sum        <= '0;
            wcnt       <= '0;
            load_error <= 1'b0;
            cpu_reset  <= 1'b1;
            state      <= LEN_LO;
          end
          LEN_LO: begin
            if (len_ok(len_in, CODE_WIDTH)) begin
              len   <= len_in;
              state <= DATA_HI;
            end else begin
              load_error <= 1'b1;
              state      <= IDLE;
            end
          end
          DATA_HI: begin
            word_hi <= rx_data;
            state   <= DATA_LO;
          end
          DATA_LO: begin
            code_we    <= 1'b1;
            code_waddr <= wcnt[CODE_WIDTH-1:0];
            code_wdata <= word_in;
            sum        <= sum + word_in;
            wcnt       <= wcnt + 1'b1;
            state      <= last_word ? SUM_HI : DATA_HI;
          end
          SUM_HI: begin
            sum_hi <= rx_data;
            state  <= SUM_LO;
          end
          SUM_LO: begin
            if (sum_in == sum) begin
              cpu_reset  <= 1'b0;
              cpu_resume <= 1'b1;
              state      <= RUN;
            end else begin
              load_error <= 1'b1;
              state      <= IDLE;
            end
          end
          default: begin
            state <= IDLE;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_code_loader.sv
module tb_code_loader;

  localparam int CW = 13;

  logic          clk = 1'b0;
  logic          reset;
  logic          rx_valid;
  logic [7:0]    rx_data;
  logic          code_we;
  logic [CW-1:0] code_waddr;
  logic [15:0]   code_wdata;
  logic          cpu_reset;
  logic          cpu_resume;
  logic          load_error;

  int checks = 0;
  int failures = 0;
  int resume_cnt = 0;
  int r0;

  logic [CW+15:0] exp_q[$];

  code_loader #(
    .CODE_WIDTH    (CW),
    .TIMEOUT_CYCLES(16)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .rx_valid  (rx_valid),
    .rx_data   (rx_data),
    .code_we   (code_we),
    .code_waddr(code_waddr),
    .code_wdata(code_wdata),
    .cpu_reset (cpu_reset),
    .cpu_resume(cpu_resume),
    .load_error(load_error)
  );

  always #5 clk = ~clk;

  // Write scoreboard and resume pulse counter, sampled mid-cycle.
  always @(negedge clk) begin
    logic [CW+15:0] e;
    if (cpu_resume === 1'b1) resume_cnt++;
    if (code_we !== 1'b0) begin
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $error("FAIL unexpected_write got addr=%0d data=%h expected no write", code_waddr, code_wdata);
      end else begin
        e = exp_q.pop_front();
        assert ({code_waddr, code_wdata} === e) else begin
          failures++;
          $error("FAIL write got addr=%0d data=%h expected addr=%0d data=%h",
                 code_waddr, code_wdata, e[CW+15:16], e[15:0]);
        end
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    rx_data  = b;
    rx_valid = 1'b1;
    @(posedge clk);
    #1;
    rx_valid = 1'b0;
  endtask

  task automatic push_write(input int addr, input logic [15:0] data);
    exp_q.push_back({CW'(addr), data});
  endtask

  task automatic send_frame(input int n, input logic [15:0] seed, input bit corrupt);
    logic [15:0] s;
    logic [15:0] w;
    logic [15:0] nn;
    s  = 16'h0000;
    nn = 16'(n);
    send_byte(nn[15:8]);
    send_byte(nn[7:0]);
    for (int i = 0; i < n; i++) begin
      w = seed + 16'(i * 7);
      s = s + w;
      send_byte(w[15:8]);
      push_write(i, w);
      send_byte(w[7:0]);
    end
    if (corrupt) s = s ^ 16'h0001;
    send_byte(s[15:8]);
    send_byte(s[7:0]);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_we"},     32'(code_we),    32'd0);
    check({tag, "_waddr"},  32'(code_waddr), 32'd0);
    check({tag, "_wdata"},  32'(code_wdata), 32'd0);
    check({tag, "_cpurst"}, 32'(cpu_reset),  32'd1);
    check({tag, "_resume"}, 32'(cpu_resume), 32'd0);
    check({tag, "_err"},    32'(load_error), 32'd0);
  endtask

  initial begin
    reset    = 1'b1;
    rx_valid = 1'b0;
    rx_data  = 8'h00;
    repeat (3) tick();
    reset = 1'b0;
    check_reset_outputs("reset");

    // Good frame 00 02 12 34 AB CD BE 01
    r0 = resume_cnt;
    send_byte(8'h00); send_byte(8'h02);
    send_byte(8'h12); push_write(0, 16'h1234); send_byte(8'h34);
    send_byte(8'hAB); push_write(1, 16'hABCD); send_byte(8'hCD);
    send_byte(8'hBE);
    check("good_hold_reset", 32'(cpu_reset), 32'd1);
    send_byte(8'h01);
    check("good_cpu_reset", 32'(cpu_reset), 32'd0);
    check("good_resume", 32'(cpu_resume), 32'd1);
    check("good_err", 32'(load_error), 32'd0);
    tick();
    check("good_resume_end", 32'(cpu_resume), 32'd0);
    check("good_still_run", 32'(cpu_reset), 32'd0);
    check("good_resume_cnt", 32'(resume_cnt - r0), 32'd1);
    check("good_q_empty", 32'(exp_q.size()), 32'd0);

    // Reload byte in RUN, then the bad-checksum frame
    r0 = resume_cnt;
    send_byte(8'h00);
    check("reload_cpu_reset", 32'(cpu_reset), 32'd1);
    send_byte(8'h02);
    send_byte(8'h12); push_write(0, 16'h1234); send_byte(8'h34);
    send_byte(8'hAB); push_write(1, 16'hABCD); send_byte(8'hCD);
    send_byte(8'hBE); send_byte(8'h02);
    check("badsum_err", 32'(load_error), 32'd1);
    check("badsum_cpu_reset", 32'(cpu_reset), 32'd1);
    tick();
    check("badsum_no_resume", 32'(resume_cnt - r0), 32'd0);
    check("badsum_q_empty", 32'(exp_q.size()), 32'd0);

    // Bad lengths
    send_byte(8'h00);
    check("len0_err_cleared", 32'(load_error), 32'd0);
    send_byte(8'h00);
    check("len0_err", 32'(load_error), 32'd1);
    send_byte(8'h20);
    send_byte(8'h01);
    check("len2001_err", 32'(load_error), 32'd1);
    check("len2001_cpu_reset", 32'(cpu_reset), 32'd1);
    tick();

    // Good frame recovers
    r0 = resume_cnt;
    send_frame(3, 16'h0100, 1'b0);
    check("recover_err", 32'(load_error), 32'd0);
    check("recover_cpu_reset", 32'(cpu_reset), 32'd0);
    tick();
    check("recover_resume_cnt", 32'(resume_cnt - r0), 32'd1);

    // Timeout after 3 bytes
    send_byte(8'h00); send_byte(8'h02); send_byte(8'h12);
    repeat (15) tick();
    check("timeout_not_yet", 32'(load_error), 32'd0);
    tick();
    check("timeout_err", 32'(load_error), 32'd1);
    check("timeout_cpu_reset", 32'(cpu_reset), 32'd1);

    // Byte arriving in the timeout cycle is accepted
    r0 = resume_cnt;
    send_byte(8'h00); send_byte(8'h01); send_byte(8'h55);
    repeat (15) tick();
    push_write(0, 16'h55AA);
    send_byte(8'hAA);
    check("tmo_edge_err", 32'(load_error), 32'd0);
    send_byte(8'h55); send_byte(8'hAA);
    check("tmo_edge_cpu_reset", 32'(cpu_reset), 32'd0);
    check("tmo_edge_err2", 32'(load_error), 32'd0);
    tick();
    check("tmo_edge_resume_cnt", 32'(resume_cnt - r0), 32'd1);

    // Full-size reload: 8192 words, addresses 0..8191
    r0 = resume_cnt;
    send_frame(8192, 16'hA5A5, 1'b0);
    check("big_cpu_reset", 32'(cpu_reset), 32'd0);
    check("big_err", 32'(load_error), 32'd0);
    tick();
    check("big_resume_cnt", 32'(resume_cnt - r0), 32'd1);
    check("big_q_empty", 32'(exp_q.size()), 32'd0);

    // Reset during DATA_LO
    send_byte(8'h00); send_byte(8'h02);
    send_byte(8'h12); push_write(0, 16'h1234); send_byte(8'h34);
    send_byte(8'hAB);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check_reset_outputs("midrst");
    r0 = resume_cnt;
    send_frame(2, 16'h7000, 1'b0);
    check("midrst_cpu_reset", 32'(cpu_reset), 32'd0);
    check("midrst_err", 32'(load_error), 32'd0);
    tick();
    check("midrst_resume_cnt", 32'(resume_cnt - r0), 32'd1);
    check("final_q_empty", 32'(exp_q.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/code_loader.md
# code_loader

Boot-time program loader in front of the CPU's code memory. It receives a framed byte stream, assembles 16-bit instruction words, and writes them to code memory from address 0. While loading it holds the CPU in reset. After a checksum-verified load it releases the CPU and issues a single resume pulse, so execution starts at address 0.

## Interface
Parameters:
- CODE_WIDTH, default `CODE_ADDR_WIDTH (13): code memory address width.
- TIMEOUT_CYCLES, default 1_000_000: maximum idle cycles between bytes inside a frame.

Ports:
- clk  in  1  system clock; the single clock domain.
- reset  in  1  synchronous, active-high; one clock, with reset synchronous and active-high.
- rx_valid  in  1  single-cycle strobe; rx_data is valid. There is no backpressure, so every strobe is consumed.
- rx_data  in  8  received byte.
- code_we  out  1  code memory write enable.
- code_waddr  out  CODE_WIDTH  code memory write address.
- code_wdata  out  16  code memory write data.
- cpu_reset  out  1  drives the CPU reset input.
- cpu_resume  out  1  one-cycle pulse, ORed into the CPU resume input.
- load_error  out  1  sticky flag: the last frame was rejected.

## Operation
- Frame format, all fields high byte first: LEN (16 bit, word count N), then N data words, then SUM (16 bit).
- SUM is the modulo-2^16 sum of the data words.
- Valid N is 1..2^CODE_WIDTH.
- States and transitions:
  - IDLE: on a byte, capture LEN hi and go to LEN_LO.
  - LEN_LO: on a byte, capture LEN lo.
    - If N is 0 or N > 2^CODE_WIDTH, go to IDLE with load_error=1.
    - Otherwise go to DATA_HI.
  - DATA_HI: on a byte, latch the word hi byte and go to DATA_LO.
  - DATA_LO: on a byte:
    - issue the write and add the word to the running sum;
    - if this is the last word go to SUM_HI, else go to DATA_HI.
  - SUM_HI: on a byte, go to SUM_LO.
  - SUM_LO: on a byte, compare against the running sum.
    - Match: go to RUN and pulse cpu_resume.
    - Mismatch: go to IDLE with load_error=1.
  - RUN: on any byte, treat it as LEN hi of a new frame and go to LEN_LO (this is a reload).
- Write addresses run 0, 1, …, N-1 and never wrap: the length check guarantees the last address is 2^CODE_WIDTH-1 at most.
- cpu_reset=1 in every state except RUN. Code written by a rejected frame is left in place, and the CPU stays in reset.
- load_error is cleared when the first byte of a new frame is accepted, in IDLE or RUN. It is set on a bad length, a checksum mismatch or a timeout.
- Timeout:
  - Applies in LEN_LO through SUM_LO.
  - The idle counter clears on every accepted byte and counts otherwise.
  - On reaching TIMEOUT_CYCLES-1 without a byte, go to IDLE with load_error=1.
  - The counter holds at 0 in IDLE and RUN.
- If rx_valid coincides with the timeout cycle, the byte wins and the counter clears.
- Reset values: state IDLE, cpu_reset=1, cpu_resume=0, code_we=0, code_waddr=0, code_wdata=0, load_error=0, sum=0, counter=0.
- A reset mid-frame discards the partial frame.

## Timing
- All outputs are registered.
- A DATA_LO byte accepted at cycle t gives code_we=1 at t+1, with the matching code_waddr and code_wdata. code_we is 0 in every other cycle.
- A matching SUM_LO byte accepted at t gives, at t+1, cpu_reset=0 and cpu_resume=1 for exactly one cycle. The CPU leaves reset and resume together, so its first fetch is address 0.
- A reload byte accepted in RUN at t gives cpu_reset=1 from t+1.
- A rejection decided at t gives load_error=1 from t+1.
- Throughput: one byte per cycle is sustained.

## Structure
- loader_pkg:
  - state typedef (IDLE, LEN_LO, DATA_HI, DATA_LO, SUM_HI, SUM_LO, RUN);
  - LEN_MAX = 1 << CODE_WIDTH.
- CODE_ADDR_WIDTH comes from constants.svh.
- One sub-module, idle_timer:
  - clear/enable inputs, expired output;
  - parameter TIMEOUT_CYCLES;
  - width $clog2(TIMEOUT_CYCLES).
- The word assembler, sum accumulator and FSM live in code_loader.

## Test plan
- Good frame. Bytes 00 02 12 34 AB CD BE 01 give writes (0,0x1234) and (1,0xABCD). cpu_reset falls one cycle after the last byte, with exactly one cpu_resume pulse. load_error=0.
- Bad checksum. Same frame with SUM 0xBE02 gives both writes, then cpu_reset stays 1, no cpu_resume, and load_error=1.
- Bad length. LEN 0x0000, and separately LEN 0x2001 with CODE_WIDTH=13, give IDLE with load_error=1 and no code_we. A following good frame loads and clears load_error.
- Timeout. Run with TIMEOUT_CYCLES=16 and stop after 3 bytes: after 16 idle cycles the FSM is in IDLE with load_error=1. A byte arriving exactly in the timeout cycle is accepted instead.
- Reload. A good frame, then a byte in RUN, gives cpu_reset=1 the next cycle. A second frame of N=8192 writes addresses 0..8191 back-to-back with no wrap, then releases the CPU.
- Reset mid-frame. Asserting reset during DATA_LO returns every output to its reset value. A fresh frame then loads from address 0.
